// File: rtl/d_inst_queue_pkg.sv
// d_inst_queue_pkg: shared definitions for the D->R decoded-instruction queue.
//   decode_pkg_t     : decoded instruction payload carried on the D->R interface.
//   INST_QUEUE_DEPTH : default queue depth, in single-instruction entries.
//   INST_W           : flattened payload width used on module ports.
package d_inst_queue_pkg;

    localparam int unsigned INST_QUEUE_DEPTH = 8;

    typedef struct packed {
        logic [15:0] pc;
        logic [7:0]  uop;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
    } decode_pkg_t;

    localparam int unsigned INST_W = $bits(decode_pkg_t);

    // Number of valid slots in a 2-slot decode pair.
    function automatic logic [1:0] popcount2(input logic [1:0] mask);
        return 2'(mask[0]) + 2'(mask[1]);
    endfunction

endpackage

// File: rtl/d_inst_queue_compact.sv
// d_inst_queue_compact: combinational 2-slot compactor.
// Moves the oldest valid instruction of a sparse decode pair into slot 0.
//   r_valid_i[1:0] : per-slot valid from decode
//   inst0_i/inst1_i: decoded instructions, slot 0 / slot 1
//   n_in_o         : number of valid instructions (0..2)
//   inst0_o/inst1_o: compacted pair; inst1_o meaningful only when n_in_o == 2
module d_inst_queue_compact
    import d_inst_queue_pkg::*;
(
    input  logic [1:0]        r_valid_i,
    input  logic [INST_W-1:0] inst0_i,
    input  logic [INST_W-1:0] inst1_i,
    output logic [1:0]        n_in_o,
    output logic [INST_W-1:0] inst0_o,
    output logic [INST_W-1:0] inst1_o
);

    assign n_in_o  = popcount2(r_valid_i);
    // Slot 1 alone shifts down into slot 0; otherwise order is already packed.
    assign inst0_o = r_valid_i[0] ? inst0_i : inst1_i;
    assign inst1_o = inst1_i;

endmodule

// File: rtl/d_inst_queue.sv
// d_inst_queue: 2-in/2-out in-order queue of decoded instructions between
// decode (D) and rename (R). Absorbs rename back-pressure, compacts sparse
// decode pairs, and is cleared by a C-stage flush.
// Optional feature macro: D_INST_QUEUE_BYPASS_EN (same-cycle bypass when empty).
// Ports:
//   clk, rst                  : clock, asynchronous active-high reset
//   d_q_valid_i / d_q_ready_o : decoder handshake
//   d_q_r_valid_i[1:0]        : per-slot valid of the incoming pair
//   d_q_inst0_i / d_q_inst1_i : incoming decoded instructions
//   q_r_valid_o / q_r_ready_i : rename handshake
//   q_r_r_valid_o[1:0]        : per-slot valid of the presented pair
//   q_r_inst0_o / q_r_inst1_o : presented instructions, oldest in slot 0
//   c_flush_i                 : discard all contents
//   empty_o                   : queue holds no instructions
module d_inst_queue
    import d_inst_queue_pkg::*;
#(
    parameter int unsigned DEPTH = INST_QUEUE_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              d_q_valid_i,
    output logic              d_q_ready_o,
    input  logic [1:0]        d_q_r_valid_i,
    input  logic [INST_W-1:0] d_q_inst0_i,
    input  logic [INST_W-1:0] d_q_inst1_i,
    output logic              q_r_valid_o,
    input  logic              q_r_ready_i,
    output logic [1:0]        q_r_r_valid_o,
    output logic [INST_W-1:0] q_r_inst0_o,
    output logic [INST_W-1:0] q_r_inst1_o,
    input  logic              c_flush_i,
    output logic              empty_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0]  wptr_q, wptr_d;
    logic [PTR_W-1:0]  rptr_q, rptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [INST_W-1:0] mem_q [DEPTH];

    logic [1:0]        n_in;
    logic [INST_W-1:0] cmp_inst0;
    logic [INST_W-1:0] cmp_inst1;
    logic              push;
    logic              bypass;
    logic              wr_en;
    logic              pop_mem;
    logic              has_one;
    logic              has_two;
    logic [1:0]        n_out;

    d_inst_queue_compact u_compact (
        .r_valid_i (d_q_r_valid_i),
        .inst0_i   (d_q_inst0_i),
        .inst1_i   (d_q_inst1_i),
        .n_in_o    (n_in),
        .inst0_o   (cmp_inst0),
        .inst1_o   (cmp_inst1)
    );

    // Room for a full pair is required even for a single instruction.
    assign d_q_ready_o = !rst && (cnt_q <= CNT_W'(DEPTH - 2)) && !c_flush_i;
    assign push        = d_q_valid_i && d_q_ready_o;

    assign has_one = (cnt_q != '0);
    assign has_two = (cnt_q >= CNT_W'(2));
    assign n_out   = has_two ? 2'd2 : 2'd1;

`ifdef D_INST_QUEUE_BYPASS_EN
    // Empty queue: present the incoming pair straight to rename.
    assign bypass = push && !has_one && (n_in != 2'd0);
`else
    assign bypass = 1'b0;
`endif

    // A bypassed pair taken by rename never touches storage.
    assign wr_en   = push && !(bypass && q_r_ready_i);
    assign pop_mem = has_one && q_r_ready_i;

    // Output presentation.
    always_comb begin
        q_r_valid_o   = has_one;
        q_r_r_valid_o = {has_two, has_one};
        q_r_inst0_o   = mem_q[rptr_q];
        q_r_inst1_o   = mem_q[rptr_q + PTR_W'(1)];
        if (bypass) begin
            q_r_valid_o   = 1'b1;
            q_r_r_valid_o = {n_in == 2'd2, 1'b1};
            q_r_inst0_o   = cmp_inst0;
            q_r_inst1_o   = cmp_inst1;
        end
    end

    assign empty_o = !has_one;

    // Pointer / occupancy next state; flush wins over push and pop.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (c_flush_i) begin
            wptr_d = '0;
            rptr_d = '0;
            cnt_d  = '0;
        end else begin
            if (wr_en) begin
                wptr_d = wptr_q + PTR_W'(n_in);
            end
            if (pop_mem) begin
                rptr_d = rptr_q + PTR_W'(n_out);
            end
            cnt_d = cnt_q + (wr_en ? CNT_W'(n_in) : CNT_W'(0))
                          - (pop_mem ? CNT_W'(n_out) : CNT_W'(0));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    // Entry storage; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (wr_en && (n_in != 2'd0)) begin
            mem_q[wptr_q] <= cmp_inst0;
        end
        if (wr_en && (n_in == 2'd2)) begin
            mem_q[wptr_q + PTR_W'(1)] <= cmp_inst1;
        end
    end

endmodule

// File: tb/tb_d_inst_queue.sv
// tb_d_inst_queue: scoreboard bench for d_inst_queue. The model is an
// unbounded queue of instructions in program order; occupancy is its size.
module tb_d_inst_queue;
    import d_inst_queue_pkg::*;

    localparam int DEPTH = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              d_q_valid_i = 1'b0;
    logic              d_q_ready_o;
    logic [1:0]        d_q_r_valid_i = 2'b00;
    logic [INST_W-1:0] d_q_inst0_i = '0;
    logic [INST_W-1:0] d_q_inst1_i = '0;
    logic              q_r_valid_o;
    logic              q_r_ready_i = 1'b0;
    logic [1:0]        q_r_r_valid_o;
    logic [INST_W-1:0] q_r_inst0_o;
    logic [INST_W-1:0] q_r_inst1_o;
    logic              c_flush_i = 1'b0;
    logic              empty_o;

    int n_cmp = 0;
    int n_bad = 0;
    int tag   = 0;

    logic [INST_W-1:0] model_q [$];

    d_inst_queue #(.DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .d_q_valid_i   (d_q_valid_i),
        .d_q_ready_o   (d_q_ready_o),
        .d_q_r_valid_i (d_q_r_valid_i),
        .d_q_inst0_i   (d_q_inst0_i),
        .d_q_inst1_i   (d_q_inst1_i),
        .q_r_valid_o   (q_r_valid_o),
        .q_r_ready_i   (q_r_ready_i),
        .q_r_r_valid_o (q_r_r_valid_o),
        .q_r_inst0_o   (q_r_inst0_o),
        .q_r_inst1_o   (q_r_inst1_o),
        .c_flush_i     (c_flush_i),
        .empty_o       (empty_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic logic [INST_W-1:0] new_inst();
        tag++;
        return INST_W'({32'($urandom()), 32'(tag)});
    endfunction

    // Drive one cycle of stimulus; inputs change 1 time unit after posedge.
    task automatic cyc(input logic v, input logic [1:0] m, input logic rdy, input logic fl);
        d_q_valid_i   = v;
        d_q_r_valid_i = m;
        d_q_inst0_i   = new_inst();
        d_q_inst1_i   = new_inst();
        q_r_ready_i   = rdy;
        c_flush_i     = fl;
        @(posedge clk);
        #1;
    endtask

    // Monitor + scoreboard: compare presented outputs to the model, then
    // apply this cycle's pop, accepted push and flush to the model.
    always @(negedge clk) begin
        int sz;
        int n_out;
        logic exp_rdy;
        logic push;
        logic byp;
        logic [INST_W-1:0] inc [$];
        if (rst) begin
            chk("rst_valid", 64'(q_r_valid_o), 64'(0));
            chk("rst_ready", 64'(d_q_ready_o), 64'(0));
            chk("rst_empty", 64'(empty_o), 64'(1));
            model_q.delete();
        end else begin
            sz      = model_q.size();
            exp_rdy = ((DEPTH - sz) >= 2) && !c_flush_i;
            chk("ready", 64'(d_q_ready_o), 64'(exp_rdy));
            chk("empty", 64'(empty_o), 64'(sz == 0));
            push = d_q_valid_i && exp_rdy;
            inc.delete();
            if (push && d_q_r_valid_i[0]) inc.push_back(d_q_inst0_i);
            if (push && d_q_r_valid_i[1]) inc.push_back(d_q_inst1_i);
            byp = 1'b0;
`ifdef D_INST_QUEUE_BYPASS_EN
            byp = push && (sz == 0) && (inc.size() != 0);
`endif
            if (byp) begin
                chk("byp_valid", 64'(q_r_valid_o), 64'(1));
                chk("byp_rvalid", 64'(q_r_r_valid_o), 64'({inc.size() == 2, 1'b1}));
                chk("byp_inst0", 64'(q_r_inst0_o), 64'(inc[0]));
                if (inc.size() == 2) chk("byp_inst1", 64'(q_r_inst1_o), 64'(inc[1]));
                if (!q_r_ready_i) begin
                    foreach (inc[i]) model_q.push_back(inc[i]);
                end
            end else begin
                chk("valid", 64'(q_r_valid_o), 64'(sz >= 1));
                chk("rvalid", 64'(q_r_r_valid_o), 64'({sz >= 2, sz >= 1}));
                if (sz >= 1) chk("inst0", 64'(q_r_inst0_o), 64'(model_q[0]));
                if (sz >= 2) chk("inst1", 64'(q_r_inst1_o), 64'(model_q[1]));
                if (c_flush_i) begin
                    model_q.delete();
                end else begin
                    if (sz >= 1 && q_r_ready_i) begin
                        n_out = (sz >= 2) ? 2 : 1;
                        repeat (n_out) void'(model_q.pop_front());
                    end
                    foreach (inc[i]) model_q.push_back(inc[i]);
                end
            end
        end
    end

    initial begin
        // Reset
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Pair push with rename stalled, then drain both
        cyc(1, 2'b11, 0, 0);
        cyc(0, 2'b00, 0, 0);
        cyc(0, 2'b00, 1, 0);
        cyc(0, 2'b00, 0, 0);

        // Sparse pairs compact into consecutive slots
        cyc(1, 2'b10, 0, 0);
        cyc(1, 2'b01, 0, 0);
        cyc(0, 2'b00, 0, 0);
        cyc(0, 2'b00, 1, 0);
        cyc(1, 2'b00, 0, 0);

        // Fill to DEPTH-1, refused push, then drain
        repeat (3) cyc(1, 2'b11, 0, 0);
        cyc(1, 2'b01, 0, 0);
        cyc(1, 2'b11, 0, 0);
        cyc(1, 2'b01, 0, 0);
        cyc(1, 2'b11, 1, 0);
        cyc(1, 2'b11, 0, 0);
        repeat (6) cyc(0, 2'b00, 1, 0);

        // Steady state through pointer wrap
        repeat (20) cyc(1, 2'b11, 1, 0);
        repeat (3) cyc(0, 2'b00, 1, 0);

        // Flush with a simultaneous push and pop
        cyc(1, 2'b11, 0, 0);
        cyc(1, 2'b11, 0, 0);
        cyc(1, 2'b01, 0, 0);
        cyc(1, 2'b11, 1, 1);
        cyc(0, 2'b00, 1, 0);
        cyc(0, 2'b00, 1, 0);

        // Asynchronous reset between edges with four entries held
        cyc(1, 2'b11, 0, 0);
        cyc(1, 2'b11, 0, 0);
        d_q_valid_i = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("async_rst_valid", 64'(q_r_valid_o), 64'(0));
        chk("async_rst_empty", 64'(empty_o), 64'(1));
        @(posedge clk);
        #1 rst = 1'b0;
        cyc(1, 2'b01, 0, 0);
        cyc(0, 2'b00, 0, 0);
        cyc(0, 2'b00, 1, 0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            cyc(($urandom_range(0, 9) < 7), 2'($urandom()),
                ($urandom_range(0, 9) < 6), ($urandom_range(0, 39) == 0));
        end
        repeat (10) cyc(0, 2'b00, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
